seg_scan_disp: RTL and testbench

//   Parametrised, time-multiplexed 7-segment driver for common-anode displays. Scans DIGITS BCD

---
 rtl/seg_scan_disp_if.sv | 22 ++
 rtl/seg_scan_disp.sv | 142 ++++++++++++++
 tb/tb_seg_scan_disp.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seg_scan_disp_if.sv
// Bundles the BCD/flag inputs and the multiplexed segment/select outputs
// of the scanned 7-segment driver.
interface seg_scan_disp_if #(
  parameter int DIGITS = 6
);
  logic [4*DIGITS-1:0] bcd_in;
  logic                max;
  logic                en;
  logic [7:0]          seg_out;
  logic [DIGITS-1:0]   dig_sel;
  logic                frame_tick;

  modport master (
    output bcd_in, max, en,
    input  seg_out, dig_sel, frame_tick
  );

  modport slave (
    input  bcd_in, max, en,
    output seg_out, dig_sel, frame_tick
  );
endinterface

// File: rtl/seg_scan_disp.sv
// Time-multiplexed common-anode 7-segment driver: one shared active-low segment
// bus, one-hot-low digit select, frame snapshot, leading-zero blanking and blink.
module seg_scan_disp #(
  parameter int              DIGITS       = 6,
  parameter int              SCAN_DIV     = 50000,
  parameter int              GUARD        = 500,
  parameter int              BLINK_FRAMES = 100,
  parameter logic [DIGITS-1:0] DP_MASK    = 6'b000100,
  parameter int              LZB_HI       = 3,
  parameter int              LZB_LO       = 2,
  parameter logic [DIGITS-1:0] MAX_MASK   = 6'b001111
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  seg_scan_disp_if.slave bus
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] GUARD_V    = DW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [IW-1:0] LZB_LO_V   = IW'(LZB_LO);
  localparam logic [IW-1:0] LZB_HI_V   = IW'(LZB_HI);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [DW-1:0]          div_cnt;
  logic [IW-1:0]          idx;
  logic [BW-1:0]          blink_cnt;
  logic                   blink_on;
  logic [4*DIGITS-1:0]    shadow_bcd;
  logic                   shadow_max;
  logic [7:0]             seg_q;
  logic [DIGITS-1:0]      sel_q;
  logic                   tick_q;

  logic                   div_wrap;
  logic                   frame_end;
  logic [3:0]             cur_digit;
  logic [DIGITS-1:0]      sel_hot;
  logic                   dp_here;
  logic                   blink_here;
  logic                   lzb_nonzero;
  logic                   blank;
  logic [7:0]             seg_nxt;
  logic [DIGITS-1:0]      sel_nxt;

  function automatic logic [7:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 8'h03;
      4'd1:    decode = 8'h9F;
      4'd2:    decode = 8'h25;
      4'd3:    decode = 8'h0D;
      4'd4:    decode = 8'h99;
      4'd5:    decode = 8'h49;
      4'd6:    decode = 8'h41;
      4'd7:    decode = 8'h1F;
      4'd8:    decode = 8'h01;
      4'd9:    decode = 8'h09;
      default: decode = 8'hFD;
    endcase
  endfunction

  assign div_wrap  = (div_cnt == DIV_LAST);
  assign frame_end = div_wrap && (idx == IDX_LAST);

  // A digit in the blanking range stays dark only if it and every digit above it up to LZB_HI are zero.
  always_comb begin
    cur_digit   = 4'd0;
    sel_hot     = '1;
    dp_here     = 1'b0;
    blink_here  = 1'b0;
    lzb_nonzero = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if (IW'(j) == idx) begin
        cur_digit  = shadow_bcd[j*4 +: 4];
        sel_hot[j] = 1'b0;
        dp_here    = DP_MASK[j];
        blink_here = MAX_MASK[j];
      end
      if ((IW'(j) >= idx) && (j <= LZB_HI) && (shadow_bcd[j*4 +: 4] != 4'd0)) begin
        lzb_nonzero = 1'b1;
      end
    end
    blank = ((idx > LZB_LO_V) && (idx <= LZB_HI_V) && !lzb_nonzero)
         || (shadow_max && blink_here && !blink_on);
    seg_nxt = decode(cur_digit);
    if (dp_here) begin
      seg_nxt[0] = 1'b0;
    end
    if (blank) begin
      seg_nxt = 8'hFF;
    end
    sel_nxt = sel_hot;
    if (div_cnt < GUARD_V) begin
      seg_nxt = 8'hFF;
      sel_nxt = '1;
    end
  end

  // Scan counters, frame snapshot and blink phase; en only masks the output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt    <= '0;
      idx        <= '0;
      blink_cnt  <= '0;
      blink_on   <= 1'b1;
      shadow_bcd <= '0;
      shadow_max <= 1'b0;
      seg_q      <= 8'hFF;
      sel_q      <= '1;
      tick_q     <= 1'b0;
    end else begin
      if (div_wrap) begin
        div_cnt <= '0;
        idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      tick_q <= frame_end;
      if (frame_end) begin
        shadow_bcd <= bus.bcd_in;
        shadow_max <= bus.max;
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
      seg_q <= bus.en ? seg_nxt : 8'hFF;
      sel_q <= bus.en ? sel_nxt : '1;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dig_sel    = sel_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_disp.sv
// Self-checking bench for seg_scan_disp: directed display patterns plus random
// inputs, compared every cycle against a frame-level behavioural model.
module tb_seg_scan_disp;

  localparam int DIGITS       = 6;
  localparam int SCAN_DIV     = 4;
  localparam int GUARD        = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int LZB_HI       = 3;
  localparam int LZB_LO       = 2;
  localparam int FRAME        = DIGITS * SCAN_DIV;
  localparam logic [5:0] DP_MASK  = 6'b000100;
  localparam logic [5:0] MAX_MASK = 6'b001111;

  logic sys_clk = 1'b0;
  logic sys_rst_n;

  seg_scan_disp_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_disp #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;

  int          check_count = 0;
  int          fail_count  = 0;
  int          n = 0;
  logic [23:0] snap_bcd = '0;
  logic        snap_max = 1'b0;
  logic [7:0]  exp_seg;
  logic [5:0]  exp_sel;
  logic        exp_tick;
  logic [7:0]  seg_rom [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    check_count++;
    if (got !== want) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, n);
    end
  endtask

  function automatic int digit_of(input logic [23:0] b, input int i);
    return int'(b[i*4 +: 4]);
  endfunction

  function automatic logic [23:0] rand_bcd();
    logic [23:0] b;
    for (int i = 0; i < DIGITS; i++) begin
      b[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    end
    return b;
  endfunction

  // Expected outputs after the edge just taken: position in the frame comes from the cycle count,
  // the displayed data from the snapshot taken at the most recent frame boundary.
  task automatic model_edge();
    int idx, div, frames;
    bit blink_on, blank;
    if (!sys_rst_n) begin
      n = 0; snap_bcd = '0; snap_max = 1'b0;
      exp_seg = 8'hFF; exp_sel = 6'h3F; exp_tick = 1'b0;
      return;
    end
    idx      = (n % FRAME) / SCAN_DIV;
    div      = n % SCAN_DIV;
    frames   = n / FRAME;
    blink_on = ((frames / BLINK_FRAMES) % 2) == 0;
    n++;
    exp_tick = (n % FRAME) == 0;
    if (!bus.en || div < GUARD) begin
      exp_seg = 8'hFF;
      exp_sel = 6'h3F;
    end else begin
      exp_sel      = 6'h3F;
      exp_sel[idx] = 1'b0;
      blank = 1'b0;
      if (idx > LZB_LO && idx <= LZB_HI) begin
        blank = 1'b1;
        for (int j = idx; j <= LZB_HI; j++) if (digit_of(snap_bcd, j) != 0) blank = 1'b0;
      end
      if (snap_max && MAX_MASK[idx] && !blink_on) blank = 1'b1;
      exp_seg = seg_rom[digit_of(snap_bcd, idx)];
      if (DP_MASK[idx]) exp_seg[0] = 1'b0;
      if (blank) exp_seg = 8'hFF;
    end
    if (exp_tick) begin
      snap_bcd = bus.bcd_in;
      snap_max = bus.max;
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge sys_clk);
      model_edge();
      @(negedge sys_clk);
      checkOutput("seg_out", 32'(bus.seg_out), 32'(exp_seg));
      checkOutput("dig_sel", 32'(bus.dig_sel), 32'(exp_sel));
      checkOutput("frame_tick", 32'(bus.frame_tick), 32'(exp_tick));
    end
  endtask

  task automatic applyStimulus(input logic [23:0] bcd, input logic mx, input logic e, input int cycles);
    bus.bcd_in = bcd;
    bus.max    = mx;
    bus.en     = e;
    step(cycles);
  endtask

  initial begin
    sys_rst_n  = 1'b0;
    bus.bcd_in = '0;
    bus.max    = 1'b0;
    bus.en     = 1'b1;
    step(2);
    sys_rst_n = 1'b1;

    applyStimulus(24'h001234, 1'b0, 1'b1, 2*FRAME);
    applyStimulus(24'h051234, 1'b0, 1'b1, 2*FRAME);
    applyStimulus(24'h000005, 1'b0, 1'b1, 2*FRAME);
    applyStimulus(24'h00A000, 1'b0, 1'b1, 2*FRAME);
    applyStimulus(24'h987650, 1'b1, 1'b1, 8*FRAME);
    applyStimulus(24'h987650, 1'b0, 1'b1, 3*FRAME);

    applyStimulus(24'h123456, 1'b0, 1'b1, 10);
    applyStimulus(24'h123456, 1'b0, 1'b0, 2*FRAME);
    applyStimulus(24'h123456, 1'b0, 1'b1, FRAME);

    for (int c = 0; c < 3*FRAME; c++) applyStimulus(rand_bcd(), 1'($urandom_range(0, 1)), 1'b1, 1);

    step(7);
    sys_rst_n = 1'b0;
    #1;
    checkOutput("async_rst_seg", 32'(bus.seg_out), 32'h0FF);
    checkOutput("async_rst_sel", 32'(bus.dig_sel), 32'h03F);
    checkOutput("async_rst_tick", 32'(bus.frame_tick), 32'h0);
    step(2);
    sys_rst_n = 1'b1;
    applyStimulus(24'h000901, 1'b1, 1'b1, 2*FRAME);

    for (int c = 0; c < 40*FRAME; c++) begin
      if ($urandom_range(0, 7) == 0) bus.bcd_in = rand_bcd();
      if ($urandom_range(0, 47) == 0) bus.max = ~bus.max;
      bus.en = ($urandom_range(0, 9) != 0);
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
